pipe_stage_skid_reg: RTL



---
 rtl/pipe_stage_skid_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, flush/hold control and
// saturating stall/flush performance counters.
module pipe_stage_skid_reg #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_CH    = 2,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     flush,
    input  logic                     hold,
    input  logic                     clr_cnt,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int                 BUS_W   = NUM_CH * DATA_W;
    localparam logic [BUS_W-1:0]   RST_BUS = {NUM_CH{RESET_VAL}};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   main_q, main_d;
    logic [BUS_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               not_empty_s;

    assign not_empty_s = (state_q != ST_EMPTY);
    // in_ready depends only on registered state, never on out_ready
    assign in_ready    = rst_n & (state_q != ST_TWO);
    assign out_valid   = rst_n & not_empty_s & ~hold & ~flush;
    assign out_data    = main_q;
    assign occupancy   = state_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_cnt_q;
    assign in_fire_s   = in_valid & in_ready;
    assign out_fire_s  = out_valid & out_ready;

    // Next-state and data path of the 2-entry skid buffer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RST_BUS;
            skid_d  = RST_BUS;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (in_fire_s && out_fire_s) begin
                        main_d  = in_data;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating counters; clear overrides the same-cycle increment
    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_d     = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            stall_d     = sat_inc(stall_q, not_empty_s & ~out_fire_s & ~flush);
            flush_cnt_d = sat_inc(flush_cnt_q, not_empty_s & flush);
        end
    end

    // State, data and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= RST_BUS;
            skid_q      <= RST_BUS;
            stall_q     <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_q     <= stall_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
